// File: rtl/clock_display_scan_if.sv
// rtl/clock_display_scan_if.sv - time bus from the CLOCK block into the display scanner
// The master side is the CLOCK block; the scanner only ever listens.
interface clock_display_scan_if;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hr;
   logic       AMPM;

   modport master (output sec, output min, output hr, output AMPM);
   modport slave  (input  sec, input  min, input  hr, input  AMPM);
endinterface

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - 6-digit multiplexed HH MM SS display driver with per-frame time snapshot
// Optional leading-zero blanking of the hours tens digit: define CLOCK_DISPLAY_LZB_EN.
module clock_display_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   clock_display_scan_if.slave        time_bus,
   output logic [5:0]                 an,
   output logic [6:0]                 seg,
   output logic                       dp
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    digit_q, digit_d;
   logic          snap_valid_q, snap_valid_d;
   logic [5:0]    snap_sec_q, snap_sec_d;
   logic [5:0]    snap_min_q, snap_min_d;
   logic [4:0]    snap_hr_q, snap_hr_d;
   logic          snap_pm_q, snap_pm_d;
   logic [5:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          term_cnt;
   logic          capture;
   logic          time_ok;
   logic          lead_blank;
   logic [2:0]    sec_tens, min_tens, hr_tens;
   logic [3:0]    digit_val;

   // Fields are all below 64, so a compare ladder is enough for the tens digit.
   function automatic logic [2:0] tens_of(input logic [5:0] v);
      if (v >= 6'd50)      return 3'd5;
      else if (v >= 6'd40) return 3'd4;
      else if (v >= 6'd30) return 3'd3;
      else if (v >= 6'd20) return 3'd2;
      else if (v >= 6'd10) return 3'd1;
      else                 return 3'd0;
   endfunction

   function automatic logic [3:0] ones_of(input logic [5:0] v, input logic [2:0] t);
      return 4'(v - 6'(t) * 6'd10);
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   always_comb begin
      term_cnt = (presc_q == PRESC_LAST);
      presc_d  = term_cnt ? '0 : presc_q + 1'b1;
      digit_d  = digit_q;
      if (term_cnt) digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;

      // The very first edge after reset loads a snapshot; later ones only at frame wrap.
      capture      = !snap_valid_q || (term_cnt && digit_q == 3'd5);
      snap_valid_d = snap_valid_q;
      snap_sec_d   = snap_sec_q;
      snap_min_d   = snap_min_q;
      snap_hr_d    = snap_hr_q;
      snap_pm_d    = snap_pm_q;
      if (capture) begin
         snap_valid_d = 1'b1;
         snap_sec_d   = time_bus.sec;
         snap_min_d   = time_bus.min;
         snap_hr_d    = time_bus.hr;
         snap_pm_d    = time_bus.AMPM;
      end

      time_ok = snap_valid_q && (snap_sec_q <= 6'd59) && (snap_min_q <= 6'd59) &&
                (snap_hr_q != 5'd0) && (snap_hr_q <= 5'd12);

      sec_tens = tens_of(snap_sec_q);
      min_tens = tens_of(snap_min_q);
      hr_tens  = tens_of({1'b0, snap_hr_q});

      case (digit_q)
         3'd0:    digit_val = ones_of(snap_sec_q, sec_tens);
         3'd1:    digit_val = {1'b0, sec_tens};
         3'd2:    digit_val = ones_of(snap_min_q, min_tens);
         3'd3:    digit_val = {1'b0, min_tens};
         3'd4:    digit_val = ones_of({1'b0, snap_hr_q}, hr_tens);
         3'd5:    digit_val = {1'b0, hr_tens};
         default: digit_val = 4'hF;
      endcase

`ifdef CLOCK_DISPLAY_LZB_EN
      lead_blank = time_ok && (digit_q == 3'd5) && (hr_tens == 3'd0);
`else
      lead_blank = 1'b0;
`endif

      if (!time_ok)        seg_d = 7'h3F;
      else if (lead_blank) seg_d = 7'h7F;
      else                 seg_d = seg_of(digit_val);

      if ((presc_q < BLANK_END) || lead_blank) an_d = 6'h3F;
      else                                      an_d = ~(6'b1 << digit_q);

      dp_d = !((digit_q == 3'd0) && time_ok && snap_pm_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         digit_q      <= 3'd0;
         snap_valid_q <= 1'b0;
         snap_sec_q   <= 6'd0;
         snap_min_q   <= 6'd0;
         snap_hr_q    <= 5'd0;
         snap_pm_q    <= 1'b0;
         an_q         <= 6'h3F;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
      end else begin
         presc_q      <= presc_d;
         digit_q      <= digit_d;
         snap_valid_q <= snap_valid_d;
         snap_sec_q   <= snap_sec_d;
         snap_min_q   <= snap_min_d;
         snap_hr_q    <= snap_hr_d;
         snap_pm_q    <= snap_pm_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Reads the time bus driven by the CLOCK block: sec, min, hr (12-hour, 1..12), AMPM.
- Drives a 6-digit, time-multiplexed, common-anode 7-segment display as HH MM SS.
- The PM indicator is shown on the decimal point of the seconds-ones digit.
- Takes a coherent snapshot of the time bus once per full scan frame, so the display never shows a torn (half-updated) time.

Parameters:
SCAN_DIV, 1000, clk cycles each digit stays selected (must be >= 2)
BLANK_CYCLES, 1, cycles at the start of each digit period during which all anodes are off (anti-ghosting); must be < SCAN_DIV

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sec  input  6  seconds, binary, valid 0..59
min  input  6  minutes, binary, valid 0..59
hr  input  5  hours, binary, valid 1..12
AMPM  input  1  0 = AM, 1 = PM
an  output  6  digit enables, active-low; an[0] = seconds ones ... an[5] = hours tens
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Reset (async assert, sync release):
  - an=6'h3F, seg=7'h7F, dp=1.
  - Prescaler=0, digit index=0, snap_valid=0, snapshot registers=0.
- Snapshot:
  - First rising clk edge after reset release: capture {sec,min,hr,AMPM} and set snap_valid=1.
  - Afterwards, capture only on the prescaler terminal count while digit index=5 (frame wrap).
  - Inputs are never used directly for display.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. On terminal count, digit index advances 0→1→…→5→0.
- Digit mapping (snapshot values):
  - 0 = sec%10, 1 = sec/10, 2 = min%10, 3 = min/10, 4 = hr%10, 5 = hr/10.
  - Binary-to-BCD is done by compare/subtract; all fields are < 60, so the tens digit is 0..5.
- Segment encoding (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Dash=3F. Blank=7F.
- Validity:
  - Snapshot is invalid if sec>59, min>59, hr==0 or hr>12.
  - Invalid snapshot: all six digits show dash and dp=1.
  - snap_valid=0 is treated as invalid.
- dp: 0 only while digit 0 is selected, the snapshot is valid, and snapshot AMPM=1. Otherwise 1.
- Anode drive:
  - an has exactly one bit low (the one for the current digit index) when prescaler >= BLANK_CYCLES.
  - an=6'h3F while prescaler < BLANK_CYCLES.
- Latency: an, seg and dp are registered, one cycle after the prescaler/digit state that selects them. All outputs are glitch-free.
- Input changes mid-frame have no visible effect until the next frame wrap.
- Reset asserted mid-frame immediately forces the reset output values.

Optional Feature:
- Macro: CLOCK_DISPLAY_LZB_EN (leading-zero blanking).
- Defined:
  - When the hours tens digit is 0 and the snapshot is valid, digit 5 shows blank: an[5] stays 1 for the whole period, seg=7F.
  - Other digits are unaffected.
- Undefined:
  - The hours tens digit 0 is shown as "0" (seg=40).

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1):
- Reset then time 12:34:56 PM, run one frame:
  - Per digit 0..5, seg = 02, 12, 19, 30, 24, 79.
  - dp=0 only on digit 0.
  - an walks 3E, 3D, 3B, 37, 2F, 1F, with one 3F cycle at the start of each period.
- Reset held high:
  - an=3F, seg=7F, dp=1 for the whole duration.
  - Release, then check the first snapshot is taken on the first edge after release.
- Time 9:05:07 AM:
  - Digits 0..4 show 78, 40, 12, 40, 10; dp=1 throughout.
  - Digit 5: with CLOCK_DISPLAY_LZB_EN, an[5] is never low; without it, seg=40.
- Change sec 56→57 while digit 2 is selected:
  - Digits 0 and 1 keep showing 6 and 5 until after the frame wrap.
  - The next frame shows 7 (seg=78).
- hr=0, and separately min=60:
  - Every digit shows seg=3F and dp=1 for the full frame.
  - Restore 1:00:00 AM; the next frame shows valid digits.
- Assert rst mid-frame at digit 3:
  - Outputs go to their reset values asynchronously.
  - After release, scan restarts at digit 0 with a fresh snapshot.
